// File: rtl/decode_cycle_pkg.sv
// Shared decode definitions for the RV32I subset: opcodes, ALU control and immediate-format codes.
// The execute stage imports the same package, so the encodings stay consistent across stages.
package decode_cycle_pkg;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    IMM_I    = 2'b00,
    IMM_S    = 2'b01,
    IMM_B    = 2'b10,
    IMM_NONE = 2'b11
  } imm_src_e;

  typedef struct packed {
    logic       reg_write;
    imm_src_e   imm_src;
    logic       alu_src;
    logic       mem_write;
    logic       result_src;
    logic       branch;
    logic [1:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/decode_cycle_register_file.sv
// 32-entry register file: two combinational read ports and one write port.
// x0 is hardwired to zero, and a same-cycle writeback is forwarded to the read ports.
module register_file #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [AW-1:0]     ra1,
  input  logic [AW-1:0]     ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2
);

  logic [DATA_W-1:0] mem [NREGS];
  logic              wr_live;

  assign wr_live = we && (wa != '0);

  // NOTE: the array is reset explicitly because every register must read 0 after reset;
  // this rules out a RAM macro, which is acceptable at this size.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (wr_live) begin
      mem[wa] <= wd;
    end
  end

  // The bypass is gated by reset so that the read ports also see zeros while reset is held.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (rst) begin
      if (wr_live && wa == ra1)  rd1 = wd;
      else if (ra1 != '0)        rd1 = mem[ra1];
      if (wr_live && wa == ra2)  rd2 = wd;
      else if (ra2 != '0)        rd2 = mem[ra2];
    end
  end

endmodule

// File: rtl/decode_cycle.sv
// Decode stage: main decoder, ALU decoder, immediate generator and the D/E pipeline register.
// It also hosts the register file, whose write port is driven from writeback.
module decode_cycle
  import decode_cycle_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       InstrD,
  input  logic [DATA_W-1:0] PCD,
  input  logic [DATA_W-1:0] PCPlus4D,
  input  logic              RegWriteW,
  input  logic [AW-1:0]     RDW,
  input  logic [DATA_W-1:0] ResultW,
  input  logic              FlushE,
  output logic              RegWriteE,
  output logic              ALUSrcE,
  output logic              MemWriteE,
  output logic              ResultSrcE,
  output logic              BranchE,
  output logic [2:0]        ALUControlE,
  output logic [DATA_W-1:0] RD1_E,
  output logic [DATA_W-1:0] RD2_E,
  output logic [DATA_W-1:0] Imm_Ext_E,
  output logic [AW-1:0]     RD_E,
  output logic [AW-1:0]     RS1_E,
  output logic [AW-1:0]     RS2_E,
  output logic [DATA_W-1:0] PCE,
  output logic [DATA_W-1:0] PCPlus4E
);

  logic [6:0]        op;
  logic [2:0]        funct3;
  logic              funct7b5;
  logic [AW-1:0]     rd, rs1, rs2;
  ctrl_t             ctrl;
  alu_ctrl_e         alu_ctrl;
  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] rd1, rd2;

  assign op       = InstrD[6:0];
  assign rd       = InstrD[11:7];
  assign funct3   = InstrD[14:12];
  assign rs1      = InstrD[19:15];
  assign rs2      = InstrD[24:20];
  assign funct7b5 = InstrD[30];

  register_file #(.DATA_W(DATA_W), .NREGS(NREGS)) u_register_file (
    .clk (clk),
    .rst (rst),
    .we  (RegWriteW),
    .wa  (RDW),
    .wd  (ResultW),
    .ra1 (rs1),
    .ra2 (rs2),
    .rd1 (rd1),
    .rd2 (rd2)
  );

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    ctrl = '0;
    unique case (op)
      OP_LW:   ctrl = '{1'b1, IMM_I, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00};
      OP_SW:   ctrl = '{1'b0, IMM_S, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00};
      OP_R:    ctrl = '{1'b1, IMM_I, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10};
      OP_I:    ctrl = '{1'b1, IMM_I, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10};
      OP_BEQ:  ctrl = '{1'b0, IMM_B, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01};
      default: ctrl = '0;
    endcase
  end

  always_comb begin
    alu_ctrl = ALU_ADD;
    case (ctrl.alu_op)
      2'b01: alu_ctrl = ALU_SUB;
      2'b10: begin
        case (funct3)
          3'b000:  alu_ctrl = (op[5] && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_ctrl = ALU_SLT;
          3'b110:  alu_ctrl = ALU_OR;
          3'b111:  alu_ctrl = ALU_AND;
          default: alu_ctrl = ALU_ADD;
        endcase
      end
      default: alu_ctrl = ALU_ADD;
    endcase
  end

  always_comb begin
    imm_ext = '0;
    case (ctrl.imm_src)
      IMM_I:   imm_ext = {{(DATA_W-12){InstrD[31]}}, InstrD[31:20]};
      IMM_S:   imm_ext = {{(DATA_W-12){InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
      IMM_B:   imm_ext = {{(DATA_W-12){InstrD[31]}}, InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
      default: imm_ext = '0;
    endcase
  end

  // NOTE: pipeline state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWriteE   <= 1'b0;
      ALUSrcE     <= 1'b0;
      MemWriteE   <= 1'b0;
      ResultSrcE  <= 1'b0;
      BranchE     <= 1'b0;
      ALUControlE <= '0;
      RD1_E       <= '0;
      RD2_E       <= '0;
      Imm_Ext_E   <= '0;
      RD_E        <= '0;
      RS1_E       <= '0;
      RS2_E       <= '0;
      PCE         <= '0;
      PCPlus4E    <= '0;
    end else begin
      // A flush only has to kill the side-effecting controls; the data fields are don't-care.
      RegWriteE   <= ctrl.reg_write  && !FlushE;
      ALUSrcE     <= ctrl.alu_src    && !FlushE;
      MemWriteE   <= ctrl.mem_write  && !FlushE;
      ResultSrcE  <= ctrl.result_src && !FlushE;
      BranchE     <= ctrl.branch     && !FlushE;
      ALUControlE <= FlushE ? 3'b000 : alu_ctrl;
      RD1_E       <= rd1;
      RD2_E       <= rd2;
      Imm_Ext_E   <= imm_ext;
      RD_E        <= rd;
      RS1_E       <= rs1;
      RS2_E       <= rs2;
      PCE         <= PCD;
      PCPlus4E    <= PCPlus4D;
    end
  end

endmodule

// File: doc/decode_cycle.md
Name: decode_cycle

Overview:
- Second pipeline stage, directly downstream of the fetch stage. Consumes InstrD/PCD/PCPlus4D and decodes an RV32I subset (lw, sw, R-type ALU, I-type ALU, beq).
- Reads the 32x32 register file and sign-extends the immediate.
- Registers all results into the D/E pipeline register that feeds the execute stage.
- Also owns the register-file write port, driven from writeback.

Parameters:
- DATA_W, 32, datapath and register width.
- NREGS, 32, number of architectural registers; index width is log2(NREGS)=5.

Ports:
- clk  in  1  clock; every register updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- InstrD  in  32  instruction from the fetch pipeline register.
- PCD  in  32  PC of InstrD.
- PCPlus4D  in  32  PC+4 of InstrD.
- RegWriteW  in  1  writeback write enable.
- RDW  in  5  writeback destination register.
- ResultW  in  32  writeback data.
- FlushE  in  1  turns the next D/E register load into a bubble (driven by PCSrcE).
- RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE  out  1 each  registered control bits.
- ALUControlE  out  3  registered ALU operation.
- RD1_E, RD2_E  out  32  registered rs1/rs2 operand values.
- Imm_Ext_E  out  32  registered sign-extended immediate.
- RD_E, RS1_E, RS2_E  out  5  registered rd/rs1/rs2 fields.
- PCE, PCPlus4E  out  32  registered PCD/PCPlus4D.

Behaviour:
- Reset: while rst=0, every E-side output is 0 and all 32 registers read 0. Reset is asynchronous and takes effect immediately, including mid-instruction.
- Latency: fields of InstrD appear on the E outputs one clk after they are present on InstrD. No stall input; the stage loads every cycle.
- Field extraction:
  - op = InstrD[6:0], rd = [11:7], funct3 = [14:12], rs1 = [19:15], rs2 = [24:20], funct7b5 = [30].
- Main decoder, control fields {RegWrite, ImmSrc[1:0], ALUSrc, MemWrite, ResultSrc, Branch, ALUOp[1:0]}:
  - 0000011 lw: 1,00,1,0,1,0,00
  - 0100011 sw: 0,01,1,1,0,0,00
  - 0110011 R-type: 1,xx→00,0,0,0,0,10
  - 0010011 I-ALU: 1,00,1,0,0,0,10
  - 1100011 beq: 0,10,0,0,0,1,01
  - any other opcode: all control 0 (acts as a NOP).
- ALU decoder:
  - ALUOp 00 → 000 (add); ALUOp 01 → 001 (sub).
  - ALUOp 10, by funct3:
    - 000: 001 (sub) if op[5]&funct7b5, else 000 (add)
    - 010: 101 (slt)
    - 110: 011 (or)
    - 111: 010 (and)
    - any other: 000.
- Immediate generation:
  - ImmSrc 00 (I): sign-extend [31:20].
  - ImmSrc 01 (S): sign-extend {[31:25],[11:7]}.
  - ImmSrc 10 (B): sign-extend {[31],[7],[30:25],[11:8],0}.
  - ImmSrc 11: 0.
- Register file:
  - Two combinational read ports and one write port. The write occurs on posedge clk when RegWriteW=1 and RDW≠0.
  - x0 always reads 0; writes to it are discarded.
  - Write-through bypass: if RegWriteW=1, RDW≠0 and RDW equals a read index, that read port returns ResultW in the same cycle. This lets an instruction in decode see a value being written back this cycle.
- Flush: FlushE=1 at a posedge loads RegWriteE, MemWriteE, BranchE, ResultSrcE, ALUSrcE and ALUControlE as 0. Data fields still load normally (don't-care). A register-file write in that same cycle still happens.
- Simultaneous rst=0 and any write: reset wins, and the register file holds 0.

Decomposition:
- Shared package: opcode constants (OP_LW, OP_SW, OP_R, OP_I, OP_BEQ), ALUControl encodings (ALU_ADD=000, ALU_SUB=001, ALU_AND=010, ALU_OR=011, ALU_SLT=101), ImmSrc encodings. The execute stage reuses these.
- One sub-module: register_file (two read ports, one write port, x0 hardwired to zero, write-through bypass, async active-low reset).
- The main decoder, ALU decoder and immediate generator stay inline in decode_cycle.

Test Plan:
- Reset: hold rst=0 with InstrD=0x00500093 → every E output 0. Release reset and apply the same instruction → after 1 clk RegWriteE=1, ALUSrcE=1, ALUControlE=000, Imm_Ext_E=5, RD_E=1.
- Write then read: RegWriteW=1, RDW=3, ResultW=0xDEADBEEF for one clk; then InstrD=0x00318233 (add x4,x3,x3) → RD1_E=RD2_E=0xDEADBEEF, RD_E=4, ALUControlE=000.
- Bypass: InstrD=0x40628133 (sub x2,x5,x6) in the same cycle as writeback RDW=5, ResultW=7 → next clk RD1_E=7, ALUControlE=001.
- x0 protection: write RDW=0, ResultW=0xFFFFFFFF; then read x0 → RD1_E=0.
- Immediates: sw 0xFE112E23 → Imm_Ext_E=0xFFFFFFFC, MemWriteE=1. beq 0xFE000EE3 → Imm_Ext_E=0xFFFFFFFC, BranchE=1, ALUControlE=001.
- Flush: lw 0x0040A183 with FlushE=1 → all E control bits 0. Unknown opcode 0x0000007F with FlushE=0 → all E control bits 0.
